int4_x2_dot_unpack: RTL and testbench

Receives the packed 24-bit products of the dual-int4 multiplier path, where one multiply computes (a·2^12 + b)·c. Each packed product is split into the two signed partial products a·c and b·c with borrow correction. Each lane is accumulated over a vector delimited by `in_last`, and the two dot-product results are presented on a valid/ready output. It sits directly after the packed multiplier in the conv/FC datapath and replaces per-lane multipliers.

---
 rtl/cnn_int4_pkg.sv | 25 ++
 rtl/int4_x2_unpack.sv | 16 +
 rtl/int4_x2_dot_unpack.sv | 120 ++++++++++++
 tb/tb_int4_x2_dot_unpack.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cnn_int4_pkg.sv
// Shared constants and the borrow-corrected split for the dual-int4 packed multiplier.
// A packed product (a*4096 + b)*c carries b*c in the low 12 bits and a*c in the high bits.
package cnn_int4_pkg;

    localparam int PACK_SHIFT = 12;
    localparam int PACK_W     = 24;
    localparam int LANE_W     = 12;

    typedef struct packed {
        logic signed [LANE_W-1:0] hi;
        logic signed [LANE_W-1:0] lo;
    } lanes_t;

    // A negative low lane borrows one from the high lane; adding lo's sign bit restores it.
    function automatic lanes_t unpack_hi_lo(input logic [PACK_W-1:0] p);
        lanes_t           r;
        logic [LANE_W:0]  hi_wide;
        hi_wide = {p[PACK_W-1], p[PACK_W-1:PACK_SHIFT]}
                + {{LANE_W{1'b0}}, p[PACK_SHIFT-1]};
        r.hi = hi_wide[LANE_W-1:0];
        r.lo = p[LANE_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/int4_x2_unpack.sv
// Combinational split of one packed product into the signed partial products a*c (hi) and b*c (lo).
module int4_x2_unpack
    import cnn_int4_pkg::*;
(
    input  logic [PACK_W-1:0]        p_i,
    output logic signed [LANE_W-1:0] hi_o,
    output logic signed [LANE_W-1:0] lo_o
);

    lanes_t lanes;

    assign lanes = unpack_hi_lo(p_i);
    assign hi_o  = lanes.hi;
    assign lo_o  = lanes.lo;

endmodule

// File: rtl/int4_x2_dot_unpack.sv
// Two-lane dot-product accumulator behind the packed int4 multiplier.
// valid/ready: a transfer happens on a rising edge where valid & ready; ready never depends on valid.
module int4_x2_dot_unpack
    import cnn_int4_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PACK_W-1:0]       in_p,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_ac,
    output logic signed [ACC_W-1:0] out_bc,
    output logic [LEN_W-1:0]        out_len,
    output logic                    out_ovf
);

    logic signed [LANE_W-1:0] hi, lo;
    logic signed [ACC_W-1:0]  term_ac, term_bc, sum_ac, sum_bc;
    logic                     ovf_ac, ovf_bc, accept;
    logic [LEN_W-1:0]         len_inc;

    logic signed [ACC_W-1:0]  acc_ac_q, acc_ac_d, acc_bc_q, acc_bc_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     ovf_q, ovf_d;
    logic signed [ACC_W-1:0]  out_ac_q, out_ac_d, out_bc_q, out_bc_d;
    logic [LEN_W-1:0]         out_len_q, out_len_d;
    logic                     out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;

    int4_x2_unpack u_unpack (
        .p_i  (in_p),
        .hi_o (hi),
        .lo_o (lo)
    );

    assign term_ac = ACC_W'(hi);
    assign term_bc = ACC_W'(lo);
    assign sum_ac  = acc_ac_q + term_ac;
    assign sum_bc  = acc_bc_q + term_bc;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign ovf_ac  = (acc_ac_q[ACC_W-1] == term_ac[ACC_W-1]) && (sum_ac[ACC_W-1] != acc_ac_q[ACC_W-1]);
    assign ovf_bc  = (acc_bc_q[ACC_W-1] == term_bc[ACC_W-1]) && (sum_bc[ACC_W-1] != acc_bc_q[ACC_W-1]);
    assign len_inc = (&len_q) ? len_q : len_q + LEN_W'(1);

    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_ac_d    = acc_ac_q;
        acc_bc_d    = acc_bc_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        out_ac_d    = out_ac_q;
        out_bc_d    = out_bc_q;
        out_len_d   = out_len_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                // Result takes this beat; accumulators restart so the next vector needs no bubble.
                out_ac_d    = sum_ac;
                out_bc_d    = sum_bc;
                out_len_d   = len_inc;
                out_ovf_d   = ovf_q || ovf_ac || ovf_bc;
                out_valid_d = 1'b1;
                acc_ac_d    = '0;
                acc_bc_d    = '0;
                len_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_ac_d = sum_ac;
                acc_bc_d = sum_bc;
                len_d    = len_inc;
                ovf_d    = ovf_q || ovf_ac || ovf_bc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_ac_q    <= '0;
            acc_bc_q    <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_ac_q    <= '0;
            out_bc_q    <= '0;
            out_len_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_ac_q    <= acc_ac_d;
            acc_bc_q    <= acc_bc_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_ac_q    <= out_ac_d;
            out_bc_q    <= out_bc_d;
            out_len_q   <= out_len_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ac    = out_ac_q;
    assign out_bc    = out_bc_q;
    assign out_len   = out_len_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_int4_x2_dot_unpack.sv
// Directed bench for int4_x2_dot_unpack: a default-width instance and a narrow one (ACC_W=12, LEN_W=2).
module tb_int4_x2_dot_unpack;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
    logic [23:0] a_in_p = '0;
    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [19:0] a_out_ac, a_out_bc;
    logic [15:0] a_out_len;

    logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
    logic [23:0] b_in_p = '0;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [11:0] b_out_ac, b_out_bc;
    logic [1:0]  b_out_len;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    int4_x2_dot_unpack dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_p(a_in_p), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ac(a_out_ac), .out_bc(a_out_bc), .out_len(a_out_len), .out_ovf(a_out_ovf)
    );

    int4_x2_dot_unpack #(.ACC_W(12), .LEN_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_p(b_in_p), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ac(b_out_ac), .out_bc(b_out_bc), .out_len(b_out_len), .out_ovf(b_out_ovf)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int v, input int ac, input int bc, input int len, input int ovf);
        check({tag, ".valid"}, {31'd0, a_out_valid}, v);
        check({tag, ".ac"},    $signed(a_out_ac),     ac);
        check({tag, ".bc"},    $signed(a_out_bc),     bc);
        check({tag, ".len"},   {16'd0, a_out_len},    len);
        check({tag, ".ovf"},   {31'd0, a_out_ovf},    ovf);
    endtask

    task automatic check_b(input string tag, input int v, input int ac, input int bc, input int len, input int ovf);
        check({tag, ".valid"}, {31'd0, b_out_valid}, v);
        check({tag, ".ac"},    $signed(b_out_ac),     ac);
        check({tag, ".bc"},    $signed(b_out_bc),     bc);
        check({tag, ".len"},   {30'd0, b_out_len},    len);
        check({tag, ".ovf"},   {31'd0, b_out_ovf},    ovf);
    endtask

    // Present one beat from the falling edge; returns 1 time unit after the rising edge.
    task automatic beat_a(input logic [23:0] p, input logic last);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_p     = p;
        a_in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic beat_b(input logic [23:0] p, input logic last);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_p     = p;
        b_in_last  = last;
        @(posedge clk);
        #1;
    endtask

    // 28623 = (-1,7,-7); 0x400400 = (-8,-8,-128); 0xC80400 = -3668992 = (7,-8,-128)
    localparam logic [23:0] P_SMALL = 24'h006FCF;
    localparam logic [23:0] P_MAXN  = 24'h400400;
    localparam logic [23:0] P_MIX   = 24'hC80400;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_a("reset_a", 0, 0, 0, 0, 0);
        check_b("reset_b", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, a_in_ready}, 1);

        // Single beat with the consumer stalled.
        beat_a(P_SMALL, 1'b1);
        check_a("single", 1, 7, -49, 1, 0);
        check("stall_ready", {31'd0, a_in_ready}, 0);

        // Pending last beat must not be taken while the result is held.
        @(negedge clk);
        a_in_p    = P_MAXN;
        a_in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_a("hold", 1, 7, -49, 1, 0);
            check("hold_ready", {31'd0, a_in_ready}, 0);
        end

        @(negedge clk);
        a_out_ready = 1'b1;
        #1;
        check("release_ready", {31'd0, a_in_ready}, 1);
        @(posedge clk);
        #1;
        check_a("extreme_neg", 1, 1024, 1024, 1, 0);

        beat_a(P_MIX, 1'b1);
        check_a("extreme_mix", 1, -896, 1024, 1, 0);
        @(negedge clk);
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", {31'd0, a_out_valid}, 0);

        // Four-beat vector followed back-to-back by a two-beat vector.
        for (int i = 0; i < 3; i++) beat_a(P_SMALL, 1'b0);
        check("four_mid_valid", {31'd0, a_out_valid}, 0);
        beat_a(P_SMALL, 1'b1);
        check_a("four", 1, 28, -196, 4, 0);
        beat_a(P_MAXN, 1'b0);
        check("b2b_consumed", {31'd0, a_out_valid}, 0);
        beat_a(P_MIX, 1'b1);
        check_a("b2b", 1, 128, 2048, 2, 0);
        @(negedge clk);
        a_in_valid = 1'b0;

        // Narrow instance: length saturation, then wrap/overflow, then a clean vector.
        for (int i = 0; i < 4; i++) beat_b(P_SMALL, 1'b0);
        beat_b(P_SMALL, 1'b1);
        check_b("len_sat", 1, 35, -245, 3, 0);
        beat_b(P_MAXN, 1'b0);
        beat_b(P_MAXN, 1'b1);
        check_b("overflow", 1, -2048, -2048, 2, 1);
        beat_b(P_SMALL, 1'b1);
        check_b("after_ovf", 1, 7, -49, 1, 0);
        @(negedge clk);
        b_in_valid = 1'b0;

        // Reset in the middle of a vector.
        beat_a(P_SMALL, 1'b0);
        beat_a(P_SMALL, 1'b0);
        @(negedge clk);
        a_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_a("async_reset", 0, 0, 0, 0, 0);
        check("async_reset_ready", {31'd0, a_in_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        beat_a(P_SMALL, 1'b1);
        check_a("after_reset", 1, 7, -49, 1, 0);
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
